// File: rtl/baud_tick_gen.sv
// Baud/sample tick generator: a programmable divisor produces a sample tick every N+1 clocks; a baud tick follows every OVERSAMPLE sample ticks.
// Latency: ticks are registered and appear one cycle after the counter wrap is detected; resync and div_load take effect at the next edge.
// Backpressure: none; en freezes both counters, and resync restarts the tick phase.
//
// Ports:
//   clk, reset     - sole clock and synchronous active-high reset
//   en             - count enable; the counters hold while it is low
//   resync         - single-cycle pulse that restarts the tick phase
//   div_load       - single-cycle strobe that captures div_in
//   div_in         - new divisor N; the sample period becomes N+1 clocks
//   s_tick, b_tick - registered single-cycle sample and baud tick pulses
//   os_phase       - index of the current sample within the baud period
//   div_busy       - a loaded divisor is pending and has not yet been applied
module baud_tick_gen #(
  parameter  int CNT_W       = 16,
  parameter  int OVERSAMPLE  = 16,
  parameter  int DEFAULT_DIV = 650,
  localparam int OS_W        = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             s_tick,
  output logic             b_tick,
  output logic [OS_W-1:0]  os_phase,
  output logic             div_busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic             div_busy_q, div_busy_d;
  logic             s_tick_q, s_tick_d;
  logic             b_tick_q, b_tick_d;

  logic wrap;
  logic apply;

  // The period boundary is the only point where the active divisor may change.
  // Swapping divisors there means no period is ever truncated or stretched.
  assign wrap  = en && (cnt_q == div_act_q);
  assign apply = resync || wrap;

  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    div_act_d  = div_act_q;
    div_shd_d  = div_shd_q;
    div_busy_d = div_busy_q;
    s_tick_d   = 1'b0;
    b_tick_d   = 1'b0;

    if (resync) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d    = '0;
        os_cnt_d = os_cnt_q + OS_W'(1);  // OVERSAMPLE is a power of two, so this wraps naturally
        s_tick_d = 1'b1;
        b_tick_d = (os_cnt_q == OS_LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (apply && div_busy_q) begin
      div_act_d  = div_shd_q;
      div_busy_d = 1'b0;
    end

    // A load that coincides with an apply is captured after the old shadow value
    // has moved to the active divisor, so it remains pending.
    if (div_load) begin
      div_shd_d  = div_in;
      div_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      div_act_q  <= DIV_RST;
      div_shd_q  <= DIV_RST;
      div_busy_q <= 1'b0;
      s_tick_q   <= 1'b0;
      b_tick_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      div_act_q  <= div_act_d;
      div_shd_q  <= div_shd_d;
      div_busy_q <= div_busy_d;
      s_tick_q   <= s_tick_d;
      b_tick_q   <= b_tick_d;
    end
  end

  assign s_tick   = s_tick_q;
  assign b_tick   = b_tick_q;
  assign os_phase = os_cnt_q;
  assign div_busy = div_busy_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        resync = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic        s_tick;
  logic        b_tick;
  logic [3:0]  os_phase;
  logic        div_busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a countdown of enabled clocks to the next sample tick,
  // plus a running total of sample ticks since the last phase restart.
  int m_rem;
  int m_ticks;
  int m_act;
  int m_shd;
  bit m_busy;
  bit e_s;
  bit e_b;

  baud_tick_gen #(
    .CNT_W(16),
    .OVERSAMPLE(16),
    .DEFAULT_DIV(650)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .resync(resync),
    .div_load(div_load),
    .div_in(div_in),
    .s_tick(s_tick),
    .b_tick(b_tick),
    .os_phase(os_phase),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit apply;
    if (reset) begin
      m_act = 650; m_shd = 650; m_busy = 0;
      m_rem = 651; m_ticks = 0; e_s = 0; e_b = 0;
    end else begin
      apply = 0; e_s = 0; e_b = 0;
      if (resync) begin
        m_ticks = 0;
        apply = 1;
      end else if (en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_ticks = m_ticks + 1;
          e_s = 1;
          e_b = (m_ticks % 16) == 0;
          apply = 1;
        end
      end
      if (apply && m_busy) begin
        m_act = m_shd;
        m_busy = 0;
      end
      if (apply) m_rem = m_act + 1;
      if (div_load) begin
        m_shd = int'(div_in);
        m_busy = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rs,
                      input logic dl, input logic [15:0] di);
    logic [3:0] e_ph;
    reset = r; en = e; resync = rs; div_load = dl; div_in = di;
    model_update();
    @(posedge clk);
    #1;
    e_ph = 4'(m_ticks % 16);
    vectors++;
    assert (s_tick === e_s) else begin
      miscompares++;
      $error("FAIL s_tick t=%0t got=%b exp=%b", $time, s_tick, e_s);
    end
    assert (b_tick === e_b) else begin
      miscompares++;
      $error("FAIL b_tick t=%0t got=%b exp=%b", $time, b_tick, e_b);
    end
    assert (os_phase === e_ph) else begin
      miscompares++;
      $error("FAIL os_phase t=%0t got=%0d exp=%0d", $time, os_phase, e_ph);
    end
    assert (div_busy === m_busy) else begin
      miscompares++;
      $error("FAIL div_busy t=%0t got=%b exp=%b", $time, div_busy, m_busy);
    end
  endtask

  // Runs enabled clocks until the DUT shows the chosen tick; n = clocks taken, -1 on timeout.
  task automatic run_until(input bit baud, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step(0, 1, 0, 0, 16'd0);
      if ((baud ? b_tick : s_tick) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int n;

    // Reset state, then the default divisor: 651-clock samples, 10416-clock baud.
    step(1, 0, 0, 0, 16'd0);
    step(1, 0, 0, 0, 16'd0);
    run_until(0, 700, n);
    expect_int("first_s_tick", n, 651);
    run_until(1, 11000, n);
    expect_int("first_b_tick", n, 10416 - 651);
    expect_int("os_phase_at_b_tick", int'(os_phase), 0);
    run_until(0, 700, n);
    expect_int("s_tick_period", n, 651);

    // Load 3 at cnt=100: the current period stays 651, later periods are 4.
    step(1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0, 16'd0);
    step(0, 1, 0, 1, 16'd3);
    expect_int("busy_after_load", int'(div_busy), 1);
    run_until(0, 700, n);
    expect_int("period_kept", n, 651 - 101);
    expect_int("busy_after_wrap", int'(div_busy), 0);
    run_until(0, 20, n);
    expect_int("new_period", n, 4);

    // Divisor 0 applied through resync: a sample tick on every clock.
    step(0, 1, 0, 1, 16'd0);
    step(0, 1, 1, 0, 16'd0);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 16'd0);

    // N=9, resync at cnt=5 with os_cnt=7.
    step(0, 1, 0, 1, 16'd9);
    step(0, 1, 1, 0, 16'd0);
    for (int i = 0; i < 75; i++) step(0, 1, 0, 0, 16'd0);
    expect_int("os_before_resync", int'(os_phase), 7);
    step(0, 1, 1, 0, 16'd0);
    run_until(0, 30, n);
    expect_int("resync_latency", n, 10);
    expect_int("phase_after_resync", int'(os_phase), 1);

    // N=9, en low for 20 clocks at cnt=4.
    step(0, 1, 1, 0, 16'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 16'd0);
    run_until(0, 30, n);
    expect_int("gap_resume", n, 6);

    // Pending load, then reset together with resync, load and en.
    step(0, 1, 0, 1, 16'd5);
    step(1, 1, 1, 1, 16'd7);
    expect_int("busy_after_reset", int'(div_busy), 0);
    run_until(0, 700, n);
    expect_int("div_after_reset", n, 651);

    // Randomized traffic with small divisors.
    step(0, 1, 0, 1, 16'd2);
    step(0, 1, 1, 0, 16'd0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 39) == 0),
           16'($urandom_range(0, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
